// File: rtl/iob_ila_capture_pkg.sv
// Shared types for the ILA capture engine: FSM state encoding as seen on state_o.
package iob_ila_capture_pkg;

    localparam int unsigned STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE  = 3'd0,
        ST_PRE   = 3'd1,
        ST_ARMED = 3'd2,
        ST_POST  = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

endpackage

// File: rtl/iob_ila_trig_unit.sv
// Trigger evaluation: per-bit negate, level/rising-edge select, mask, OR/AND combine, forced trigger.
module iob_ila_trig_unit #(
    parameter int unsigned TRIGGER_W = 4
) (
    input  logic                 clk_i,
    input  logic                 arst_n_i,
    input  logic                 sample_i,
    input  logic [TRIGGER_W-1:0] trigger_i,
    input  logic [TRIGGER_W-1:0] trig_type_i,
    input  logic [TRIGGER_W-1:0] trig_negate_i,
    input  logic [TRIGGER_W-1:0] trig_mask_i,
    input  logic                 trig_and_i,
    input  logic                 force_trig_i,
    output logic                 fire_o
);

    logic [TRIGGER_W-1:0] t;
    logic [TRIGGER_W-1:0] t_prev;
    logic [TRIGGER_W-1:0] hit;

    assign t   = trigger_i ^ trig_negate_i;
    assign hit = (trig_type_i & t & ~t_prev) | (~trig_type_i & t);

    // Edge history follows every qualified sample regardless of capture state.
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            t_prev <= '0;
        end else if (sample_i) begin
            t_prev <= t;
        end
    end

    always_comb begin
        fire_o = 1'b0;
        if (trig_and_i) begin
            fire_o = (trig_mask_i != '0) & (&(hit | ~trig_mask_i));
        end else begin
            fire_o = |(hit & trig_mask_i);
        end
        fire_o = fire_o | force_trig_i;
    end

endmodule

// File: rtl/iob_ila_capture.sv
// ILA capture engine: circular sample buffer with pre-trigger depth, trigger FSM and logical-index read port.
module iob_ila_capture
    import iob_ila_capture_pkg::*;
#(
    parameter int unsigned SIGNAL_W  = 32,
    parameter int unsigned TRIGGER_W = 4,
    parameter int unsigned BUFFER_W  = 4
) (
    input  logic                 clk_i,
    input  logic                 arst_n_i,
    input  logic                 cke_i,
    input  logic [SIGNAL_W-1:0]  signal_i,
    input  logic [TRIGGER_W-1:0] trigger_i,
    input  logic                 sample_en_i,
    input  logic                 arm_i,
    input  logic                 clear_i,
    input  logic                 force_trig_i,
    input  logic [TRIGGER_W-1:0] trig_type_i,
    input  logic [TRIGGER_W-1:0] trig_negate_i,
    input  logic [TRIGGER_W-1:0] trig_mask_i,
    input  logic                 trig_and_i,
    input  logic [BUFFER_W:0]    pretrig_i,
    input  logic                 rd_en_i,
    input  logic [BUFFER_W-1:0]  rd_addr_i,
    output logic [SIGNAL_W-1:0]  rd_data_o,
    output logic                 rd_valid_o,
    output logic [STATE_W-1:0]   state_o,
    output logic [BUFFER_W:0]    n_samples_o,
    output logic [BUFFER_W-1:0]  trig_idx_o,
    output logic                 done_o
);

    localparam int unsigned DEPTH = 2 ** BUFFER_W;
    localparam int unsigned CW    = BUFFER_W + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] PT_MAX  = CW'(DEPTH - 1);

    state_t              state, state_nxt;
    logic [CW-1:0]       cnt, cnt_nxt, cnt_inc;
    logic [CW-1:0]       pt, pt_nxt;
    logic [BUFFER_W-1:0] wp, wp_nxt;
    logic [BUFFER_W-1:0] trig_idx, trig_idx_nxt;
    logic [BUFFER_W-1:0] rd_phys;
    logic                sample;
    logic                fire;
    logic                we;

    logic [SIGNAL_W-1:0] mem [DEPTH];

    assign sample = cke_i & sample_en_i;

    iob_ila_trig_unit #(
        .TRIGGER_W(TRIGGER_W)
    ) u_trig (
        .clk_i        (clk_i),
        .arst_n_i     (arst_n_i),
        .sample_i     (sample),
        .trigger_i    (trigger_i),
        .trig_type_i  (trig_type_i),
        .trig_negate_i(trig_negate_i),
        .trig_mask_i  (trig_mask_i),
        .trig_and_i   (trig_and_i),
        .force_trig_i (force_trig_i),
        .fire_o       (fire)
    );

    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        pt_nxt       = pt;
        wp_nxt       = wp;
        trig_idx_nxt = trig_idx;
        we           = 1'b0;
        cnt_inc      = cnt + 1'b1;
        if (clear_i) begin
            state_nxt = ST_IDLE;
            cnt_nxt   = '0;
        end else if (arm_i) begin
            pt_nxt    = (pretrig_i > PT_MAX) ? PT_MAX : pretrig_i;
            wp_nxt    = '0;
            cnt_nxt   = '0;
            state_nxt = (pt_nxt == '0) ? ST_ARMED : ST_PRE;
        end else if (sample) begin
            unique case (state)
                ST_PRE: begin
                    we      = 1'b1;
                    wp_nxt  = wp + 1'b1;
                    cnt_nxt = cnt_inc;
                    if (cnt_inc >= pt) state_nxt = ST_ARMED;
                end
                ST_ARMED: begin
                    we     = 1'b1;
                    wp_nxt = wp + 1'b1;
                    if (fire) begin
                        cnt_nxt      = cnt_inc;
                        trig_idx_nxt = cnt[BUFFER_W-1:0];
                        state_nxt    = (cnt_inc == DEPTH_C) ? ST_DONE : ST_POST;
                    end else begin
                        // Window saturates at pt: the oldest pre-trigger sample is overwritten.
                        cnt_nxt = (cnt_inc > pt) ? pt : cnt_inc;
                    end
                end
                ST_POST: begin
                    we      = 1'b1;
                    wp_nxt  = wp + 1'b1;
                    cnt_nxt = cnt_inc;
                    if (cnt_inc == DEPTH_C) state_nxt = ST_DONE;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            pt       <= '0;
            wp       <= '0;
            trig_idx <= '0;
        end else if (cke_i) begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            pt       <= pt_nxt;
            wp       <= wp_nxt;
            trig_idx <= trig_idx_nxt;
        end
    end

    always_ff @(posedge clk_i) begin
        if (we) mem[wp] <= signal_i;
    end

    // Logical index 0 is the oldest sample; cnt == DEPTH wraps to wp itself.
    assign rd_phys = wp - cnt[BUFFER_W-1:0] + rd_addr_i;

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            rd_data_o  <= '0;
            rd_valid_o <= 1'b0;
        end else if (cke_i) begin
            rd_valid_o <= rd_en_i;
            if (rd_en_i) begin
                rd_data_o <= ({1'b0, rd_addr_i} < cnt) ? mem[rd_phys] : '0;
            end
        end
    end

    assign state_o     = state;
    assign n_samples_o = cnt;
    assign trig_idx_o  = trig_idx;
    assign done_o      = (state == ST_DONE);

endmodule

// File: tb/tb_iob_ila_capture.sv
// Directed bench for iob_ila_capture: signal_i = k on the k-th qualified sample, DEPTH = 16.
module tb_iob_ila_capture;

    logic        clk = 1'b0;
    logic        arst_n_i;
    logic        cke_i;
    logic [31:0] signal_i;
    logic [3:0]  trigger_i;
    logic        sample_en_i;
    logic        arm_i;
    logic        clear_i;
    logic        force_trig_i;
    logic [3:0]  trig_type_i;
    logic [3:0]  trig_negate_i;
    logic [3:0]  trig_mask_i;
    logic        trig_and_i;
    logic [4:0]  pretrig_i;
    logic        rd_en_i;
    logic [3:0]  rd_addr_i;
    logic [31:0] rd_data_o;
    logic        rd_valid_o;
    logic [2:0]  state_o;
    logic [4:0]  n_samples_o;
    logic [3:0]  trig_idx_o;
    logic        done_o;

    int checks   = 0;
    int failures = 0;
    int k        = 0;

    iob_ila_capture #(
        .SIGNAL_W (32),
        .TRIGGER_W(4),
        .BUFFER_W (4)
    ) dut (
        .clk_i        (clk),
        .arst_n_i     (arst_n_i),
        .cke_i        (cke_i),
        .signal_i     (signal_i),
        .trigger_i    (trigger_i),
        .sample_en_i  (sample_en_i),
        .arm_i        (arm_i),
        .clear_i      (clear_i),
        .force_trig_i (force_trig_i),
        .trig_type_i  (trig_type_i),
        .trig_negate_i(trig_negate_i),
        .trig_mask_i  (trig_mask_i),
        .trig_and_i   (trig_and_i),
        .pretrig_i    (pretrig_i),
        .rd_en_i      (rd_en_i),
        .rd_addr_i    (rd_addr_i),
        .rd_data_o    (rd_data_o),
        .rd_valid_o   (rd_valid_o),
        .state_o      (state_o),
        .n_samples_o  (n_samples_o),
        .trig_idx_o   (trig_idx_o),
        .done_o       (done_o)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic qsample(input logic [3:0] trig, input logic frc);
        k            = k + 1;
        signal_i     = 32'(k);
        trigger_i    = trig;
        force_trig_i = frc;
        sample_en_i  = 1'b1;
        tick(1);
        sample_en_i  = 1'b0;
        force_trig_i = 1'b0;
        trigger_i    = '0;
    endtask

    task automatic arm(input logic [4:0] pre);
        pretrig_i = pre;
        arm_i     = 1'b1;
        tick(1);
        arm_i     = 1'b0;
        k         = 0;
    endtask

    task automatic clear_cap();
        clear_i = 1'b1;
        tick(1);
        clear_i = 1'b0;
    endtask

    task automatic set_trig(input logic [3:0] ty, input logic [3:0] ng, input logic [3:0] mk, input logic am);
        trig_type_i   = ty;
        trig_negate_i = ng;
        trig_mask_i   = mk;
        trig_and_i    = am;
    endtask

    task automatic do_read(input logic [3:0] a, output logic [31:0] d, output logic v);
        rd_en_i   = 1'b1;
        rd_addr_i = a;
        tick(1);
        rd_en_i   = 1'b0;
        d         = rd_data_o;
        v         = rd_valid_o;
    endtask

    task automatic test_reset();
        arst_n_i = 1'b0; cke_i = 1'b1; signal_i = '0; trigger_i = '0; sample_en_i = 1'b0;
        arm_i = 1'b0; clear_i = 1'b0; force_trig_i = 1'b0; pretrig_i = '0;
        rd_en_i = 1'b0; rd_addr_i = '0;
        set_trig(4'b0000, 4'b0000, 4'b0000, 1'b0);
        #12;
        checks++; if (state_o !== 3'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", state_o); end
        checks++; if ({n_samples_o, trig_idx_o, done_o, rd_valid_o} !== 11'd0) begin failures++; $display("FAIL reset_status got=%0h exp=0", {n_samples_o, trig_idx_o, done_o, rd_valid_o}); end
        checks++; if (rd_data_o !== 32'd0) begin failures++; $display("FAIL reset_rd_data got=%0h exp=0", rd_data_o); end
        @(negedge clk);
        arst_n_i = 1'b1;
        tick(2);
    endtask

    task automatic test_level_or();
        logic [31:0] d; logic v;
        set_trig(4'b0000, 4'b0000, 4'b0001, 1'b0);
        arm(5'd4);
        checks++; if (state_o !== 3'd1) begin failures++; $display("FAIL t1_pre got=%0d exp=1", state_o); end
        for (int i = 1; i <= 4; i++) qsample(4'b0000, 1'b0);
        checks++; if (state_o !== 3'd2) begin failures++; $display("FAIL t1_armed got=%0d exp=2", state_o); end
        for (int i = 5; i <= 9; i++) qsample(4'b0000, 1'b0);
        checks++; if (n_samples_o !== 5'd4) begin failures++; $display("FAIL t1_sat_cnt got=%0d exp=4", n_samples_o); end
        for (int i = 10; i <= 20; i++) qsample(4'b0001, 1'b0);
        checks++; if (state_o !== 3'd3) begin failures++; $display("FAIL t1_post got=%0d exp=3", state_o); end
        qsample(4'b0001, 1'b0);
        checks++; if (state_o !== 3'd4 || done_o !== 1'b1) begin failures++; $display("FAIL t1_done got=%0d/%0b exp=4/1", state_o, done_o); end
        checks++; if (n_samples_o !== 5'd16) begin failures++; $display("FAIL t1_n got=%0d exp=16", n_samples_o); end
        checks++; if (trig_idx_o !== 4'd4) begin failures++; $display("FAIL t1_trig_idx got=%0d exp=4", trig_idx_o); end
        do_read(4'd0, d, v);
        checks++; if (d !== 32'd6 || v !== 1'b1) begin failures++; $display("FAIL t1_rd0 got=%0d/%0b exp=6/1", d, v); end
        tick(1);
        checks++; if (rd_valid_o !== 1'b0 || rd_data_o !== 32'd6) begin failures++; $display("FAIL t1_rd_hold got=%0d/%0b exp=6/0", rd_data_o, rd_valid_o); end
        do_read(4'd4, d, v);
        checks++; if (d !== 32'd10) begin failures++; $display("FAIL t1_rd4 got=%0d exp=10", d); end
        qsample(4'b0001, 1'b0);
        do_read(4'd15, d, v);
        checks++; if (d !== 32'd21 || n_samples_o !== 5'd16) begin failures++; $display("FAIL t1_done_hold got=%0d/%0d exp=21/16", d, n_samples_o); end
        clear_cap();
    endtask

    task automatic test_edge_negate();
        logic [31:0] d; logic v;
        set_trig(4'b0010, 4'b0010, 4'b0010, 1'b0);
        arm(5'd4);
        for (int i = 1; i <= 6; i++) qsample(4'b0010, 1'b0);
        checks++; if (state_o !== 3'd2) begin failures++; $display("FAIL t2_no_fire got=%0d exp=2", state_o); end
        qsample(4'b0000, 1'b0);
        checks++; if (state_o !== 3'd3 || trig_idx_o !== 4'd4) begin failures++; $display("FAIL t2_fire got=%0d/%0d exp=3/4", state_o, trig_idx_o); end
        do_read(4'd4, d, v);
        checks++; if (d !== 32'd7) begin failures++; $display("FAIL t2_rd_trig got=%0d exp=7", d); end
        do_read(4'd0, d, v);
        checks++; if (d !== 32'd3) begin failures++; $display("FAIL t2_rd0 got=%0d exp=3", d); end
        clear_cap();
    endtask

    task automatic test_and_combine();
        logic [31:0] d; logic v;
        set_trig(4'b0000, 4'b0000, 4'b0101, 1'b1);
        arm(5'd2);
        qsample(4'b0000, 1'b0); qsample(4'b0000, 1'b0);
        qsample(4'b0001, 1'b0); qsample(4'b0000, 1'b0);
        qsample(4'b0100, 1'b0); qsample(4'b0000, 1'b0);
        qsample(4'b0000, 1'b0); qsample(4'b0000, 1'b0);
        checks++; if (state_o !== 3'd2) begin failures++; $display("FAIL t3_no_fire got=%0d exp=2", state_o); end
        qsample(4'b0101, 1'b0);
        checks++; if (state_o !== 3'd3 || trig_idx_o !== 4'd2 || n_samples_o !== 5'd3) begin failures++; $display("FAIL t3_fire got=%0d/%0d/%0d exp=3/2/3", state_o, trig_idx_o, n_samples_o); end
        do_read(4'd2, d, v);
        checks++; if (d !== 32'd9) begin failures++; $display("FAIL t3_rd_trig got=%0d exp=9", d); end
        do_read(4'd0, d, v);
        checks++; if (d !== 32'd7) begin failures++; $display("FAIL t3_rd0 got=%0d exp=7", d); end
        do_read(4'd5, d, v);
        checks++; if (d !== 32'd0 || v !== 1'b1) begin failures++; $display("FAIL t3_rd_oob got=%0d/%0b exp=0/1", d, v); end
        clear_cap();
    endtask

    task automatic test_pretrig_bounds();
        logic [31:0] d; logic v;
        set_trig(4'b0000, 4'b0000, 4'b0001, 1'b0);
        arm(5'd20);
        for (int i = 1; i <= 29; i++) qsample(4'b0000, 1'b0);
        checks++; if (state_o !== 3'd2 || n_samples_o !== 5'd15) begin failures++; $display("FAIL t4_clamp got=%0d/%0d exp=2/15", state_o, n_samples_o); end
        qsample(4'b0001, 1'b0);
        checks++; if (state_o !== 3'd4 || trig_idx_o !== 4'd15) begin failures++; $display("FAIL t4_done got=%0d/%0d exp=4/15", state_o, trig_idx_o); end
        do_read(4'd15, d, v);
        checks++; if (d !== 32'd30) begin failures++; $display("FAIL t4_rd15 got=%0d exp=30", d); end
        do_read(4'd0, d, v);
        checks++; if (d !== 32'd15) begin failures++; $display("FAIL t4_rd0 got=%0d exp=15", d); end
        arm(5'd0);
        checks++; if (state_o !== 3'd2 || n_samples_o !== 5'd0) begin failures++; $display("FAIL t4_pt0_armed got=%0d/%0d exp=2/0", state_o, n_samples_o); end
        qsample(4'b0000, 1'b1);
        checks++; if (state_o !== 3'd3 || trig_idx_o !== 4'd0 || n_samples_o !== 5'd1) begin failures++; $display("FAIL t4_force got=%0d/%0d/%0d exp=3/0/1", state_o, trig_idx_o, n_samples_o); end
        do_read(4'd0, d, v);
        checks++; if (d !== 32'd1) begin failures++; $display("FAIL t4_pt0_rd got=%0d exp=1", d); end
    endtask

    task automatic test_clear();
        logic [31:0] d; logic v;
        qsample(4'b0000, 1'b0);
        checks++; if (state_o !== 3'd3) begin failures++; $display("FAIL t5_in_post got=%0d exp=3", state_o); end
        clear_cap();
        checks++; if (state_o !== 3'd0 || n_samples_o !== 5'd0) begin failures++; $display("FAIL t5_clear got=%0d/%0d exp=0/0", state_o, n_samples_o); end
        for (int i = 0; i < 3; i++) qsample(4'b0001, 1'b0);
        do_read(4'd0, d, v);
        checks++; if (state_o !== 3'd0 || n_samples_o !== 5'd0 || d !== 32'd0) begin failures++; $display("FAIL t5_idle_hold got=%0d/%0d/%0d exp=0/0/0", state_o, n_samples_o, d); end
        arm(5'd3);
        qsample(4'b0000, 1'b0);
        checks++; if (state_o !== 3'd1 || n_samples_o !== 5'd1) begin failures++; $display("FAIL t5_rearm got=%0d/%0d exp=1/1", state_o, n_samples_o); end
        arm_i = 1'b1; clear_i = 1'b1;
        tick(1);
        arm_i = 1'b0; clear_i = 1'b0;
        checks++; if (state_o !== 3'd0 || n_samples_o !== 5'd0) begin failures++; $display("FAIL t5_arm_clear got=%0d/%0d exp=0/0", state_o, n_samples_o); end
    endtask

    task automatic test_qualify_and_async_reset();
        logic [31:0] d; logic v;
        set_trig(4'b0000, 4'b0000, 4'b0001, 1'b0);
        arm(5'd2);
        qsample(4'b0000, 1'b0);
        signal_i = 32'hdead; trigger_i = 4'b0001;
        tick(1);
        qsample(4'b0000, 1'b0);
        signal_i = 32'hdead; trigger_i = 4'b0001;
        tick(1);
        checks++; if (state_o !== 3'd2 || n_samples_o !== 5'd2) begin failures++; $display("FAIL t6_unqual got=%0d/%0d exp=2/2", state_o, n_samples_o); end
        cke_i = 1'b0; sample_en_i = 1'b1; signal_i = 32'hbeef; trigger_i = 4'b0001; rd_en_i = 1'b1;
        tick(2);
        cke_i = 1'b1; sample_en_i = 1'b0; trigger_i = 4'b0000; rd_en_i = 1'b0;
        checks++; if (state_o !== 3'd2 || n_samples_o !== 5'd2 || rd_valid_o !== 1'b0) begin failures++; $display("FAIL t6_cke_freeze got=%0d/%0d/%0b exp=2/2/0", state_o, n_samples_o, rd_valid_o); end
        qsample(4'b0000, 1'b0);
        qsample(4'b0001, 1'b0);
        checks++; if (state_o !== 3'd3 || trig_idx_o !== 4'd2 || n_samples_o !== 5'd3) begin failures++; $display("FAIL t6_fire got=%0d/%0d/%0d exp=3/2/3", state_o, trig_idx_o, n_samples_o); end
        do_read(4'd0, d, v);
        checks++; if (d !== 32'd2) begin failures++; $display("FAIL t6_rd0 got=%0h exp=2", d); end
        do_read(4'd1, d, v);
        checks++; if (d !== 32'd3) begin failures++; $display("FAIL t6_rd1 got=%0h exp=3", d); end
        do_read(4'd2, d, v);
        checks++; if (d !== 32'd4) begin failures++; $display("FAIL t6_rd2 got=%0h exp=4", d); end
        rd_en_i = 1'b1; rd_addr_i = 4'd0;
        qsample(4'b0000, 1'b0);
        rd_en_i = 1'b0;
        checks++; if (rd_valid_o !== 1'b1 || n_samples_o !== 5'd4) begin failures++; $display("FAIL t6_rd_wr got=%0b/%0d exp=1/4", rd_valid_o, n_samples_o); end
        #2;
        arst_n_i = 1'b0;
        #1;
        checks++; if (state_o !== 3'd0 || n_samples_o !== 5'd0 || trig_idx_o !== 4'd0) begin failures++; $display("FAIL t6_arst_state got=%0d/%0d/%0d exp=0/0/0", state_o, n_samples_o, trig_idx_o); end
        checks++; if (rd_data_o !== 32'd0 || rd_valid_o !== 1'b0 || done_o !== 1'b0) begin failures++; $display("FAIL t6_arst_rd got=%0h/%0b/%0b exp=0/0/0", rd_data_o, rd_valid_o, done_o); end
        @(negedge clk);
        arst_n_i = 1'b1;
        tick(1);
    endtask

    initial begin
        test_reset();
        test_level_or();
        test_edge_negate();
        test_and_combine();
        test_pretrig_bounds();
        test_clear();
        test_qualify_and_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
